imem_fetch_responder: RTL and testbench

- Responder side of the instruction-fetch interface: the core issues a word address and this block returns the 32-bit instruction word.
- Replaces the ideal zero-latency instruction memory with a synchronous, handshaked memory that has configurable wait states.
- Has a loader write port so the bench or boot logic can place a program before or between fetches.
- Sits between the core's PC/IR path and the program storage.

---
 rtl/imem_fetch_responder.sv | 123 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: handshaked synchronous instruction memory with LATENCY wait states and a loader port.
// Optional build macro IMEM_RANGE_CHECK_EN: out-of-range fetches return resp_err=1 instead of wrapping.
module imem_fetch_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy
);

    // Handshakes: a transfer happens on a posedge where valid and ready are both high;
    // the responder holds resp_valid/resp_data/resp_err stable until that edge.
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
    localparam bit              MULTI    = (LATENCY > 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mem [DEPTH];
    logic [3:0]  cnt;
    logic [31:0] data_q;
    logic        err_q;
    logic        accept;
    logic        handshake;
    logic        load_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0] rd_word;
    logic        rd_err;

    assign accept        = (state == IDLE) && req_valid;
    assign handshake     = (state == RESP) && resp_ready;
    assign load_in_range = {1'b0, load_addr} < DEPTH_X;

`ifdef IMEM_RANGE_CHECK_EN
    logic req_in_range;
    assign req_in_range = {1'b0, req_addr} < DEPTH_X;
    assign rd_idx       = IDX_W'(req_addr);
    assign rd_word      = req_in_range ? mem[rd_idx] : 32'h0;
    assign rd_err       = !req_in_range;
`else
    // Wrapping build: the address folds onto storage and never raises an error.
    assign rd_idx  = IDX_W'({1'b0, req_addr} % DEPTH_X);
    assign rd_word = mem[rd_idx];
    assign rd_err  = 1'b0;
`endif

    // Storage is not reset; a same-edge fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[IDX_W'(load_addr)] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = MULTI ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    // The response registers are zero outside RESP so a stray sample reads as a NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            data_q    <= 32'h0;
            err_q     <= 1'b0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= rd_word;
                err_q  <= rd_err;
                cnt    <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (accept && !MULTI) begin
                resp_data <= rd_word;
                resp_err  <= rd_err;
            end else if ((state == WAIT) && (cnt == 4'd1)) begin
                resp_data <= data_q;
                resp_err  <= err_q;
            end else if (handshake) begin
                resp_data <= 32'h0;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed steps plus randomized fetch/load traffic against an array model.
// Honours IMEM_RANGE_CHECK_EN the same way the design does.
module tb_imem_fetch_responder;

    localparam int AW    = 11;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AWB   = 4;
    localparam int DEPB  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en, busy;
    logic [AW-1:0] req_addr, load_addr;
    logic [31:0]   resp_data, load_data;

    logic           req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b, load_en_b, busy_b;
    logic [AWB-1:0] req_addr_b, load_addr_b;
    logic [31:0]    resp_data_b, load_data_b;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_b [DEPB];
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    imem_fetch_responder #(.ADDR_W(AWB), .DEPTH(DEPB), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_data(resp_data_b), .resp_err(resp_err_b), .load_en(load_en_b),
        .load_addr(load_addr_b), .load_data(load_data_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a fetch returns {err, word} from the program array.
    function automatic logic [32:0] model_fetch(input int a);
`ifdef IMEM_RANGE_CHECK_EN
        if (a >= DEPTH) return {1'b1, 32'h0};
        return {1'b0, ref_mem[a]};
`else
        return {1'b0, ref_mem[a % DEPTH]};
`endif
    endfunction

    task automatic do_load(input int a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = AW'(a); load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        if (a < DEPTH) ref_mem[a] = d;
    endtask

    task automatic do_load_b(input int a, input logic [31:0] d);
        @(negedge clk);
        load_en_b = 1'b1; load_addr_b = AWB'(a); load_data_b = d;
        @(negedge clk);
        load_en_b = 1'b0;
        ref_b[a] = d;
    endtask

    // One fetch: optional load on the accept edge, optional load to the same word just after accept,
    // and 'stall' extra cycles of resp_ready=0 while a second request waits on req_valid.
    task automatic fetch(input int a, input int stall, input bit same_ld, input logic [31:0] same_d,
                         input bit mid_ld, input logic [31:0] mid_d);
        logic [32:0] e;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        e = model_fetch(a);
        req_valid = 1'b1; req_addr = AW'(a); resp_ready = 1'b0;
        if (same_ld) begin load_en = 1'b1; load_addr = AW'(a); load_data = same_d; end
        @(posedge clk);
        if (same_ld && a < DEPTH) ref_mem[a] = same_d;
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b0;
        if (mid_ld) begin
            load_en = 1'b1; load_addr = AW'(a); load_data = mid_d;
            if (a < DEPTH) ref_mem[a] = mid_d;
        end
        for (int j = 0; j < LAT - 1; j++) begin
            chk("wait_resp_valid", 32'(resp_valid), 32'd0);
            chk("wait_req_ready", 32'(req_ready), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_resp_data", resp_data, 32'h0);
            @(negedge clk);
            load_en = 1'b0;
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", resp_data, e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(e[32]));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1; req_addr = AW'(a + 1);
            @(negedge clk);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_resp_data", resp_data, e[31:0]);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b0; load_en = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_resp_data", resp_data, 32'h0);
        chk("post_resp_err", 32'(resp_err), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit phase;
        int a;
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid_b = 1'b0; req_addr_b = '0; resp_ready_b = 1'b0;
        load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) do_load(i, 32'h0);

        // Basic fetch after placing a small program.
        do_load(0, 32'h2008_0005);
        do_load(1, 32'h2009_000A);
        fetch(0, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Held response, then queued requests.
        fetch(0, 3, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(1, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(2, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Read-before-write on the accept edge, then the new word.
        fetch(4, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        fetch(4, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset during WAIT drops the request immediately.
        @(negedge clk);
        req_valid = 1'b1; req_addr = AW'(1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wait_before_reset_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dropped_no_resp", 32'(resp_valid), 32'd0);
        end
        fetch(1, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Out-of-range fetch and ignored out-of-range load.
        do_load(1030, 32'hBAD0_0001);
        fetch(1025, 1, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(6, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(($urandom_range(0, 3) == 0) ? 1024 + $urandom_range(0, 63) : $urandom_range(0, 63), $urandom);
            a = ($urandom_range(0, 3) == 0) ? 1024 + $urandom_range(0, 63) : $urandom_range(0, 63);
            fetch(a, $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0), $urandom,
                  1'($urandom_range(0, 2) == 0), $urandom);
        end

        // Single-cycle-latency instance: accept every other cycle with resp_ready held high.
        for (int i = 0; i < DEPB; i++) do_load_b(i, $urandom);
        @(negedge clk);
        req_valid_b = 1'b1; resp_ready_b = 1'b1;
        phase = 1'b0;
        for (int c = 0; c < 24; c++) begin
            chk("b_req_ready", 32'(req_ready_b), 32'(!phase));
            chk("b_resp_valid", 32'(resp_valid_b), 32'(phase));
            if (phase) begin
                chk("b_resp_data", resp_data_b, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
            end else begin
                chk("b_idle_resp_data", resp_data_b, 32'h0);
            end
            req_addr_b = AWB'($urandom_range(0, DEPB - 1));
            if (!phase) exp_q.push_back(ref_b[req_addr_b]);
            phase = !phase;
            @(negedge clk);
        end
        req_valid_b = 1'b0; resp_ready_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
